spi_rx_frame_ctrl: RTL
======================

Name: spi_rx_frame_ctrl

Overview:
Frame-level controller behind the SPI byte receiver. It consumes the receiver's byte stream (byte plus one-cycle valid strobe) and the synchronized chip-select. It parses command/length/data/checksum frames and buffers write payloads, committing them to a register bus only after the checksum passes. Read frames become a single request to the transmit side, and every frame completes with a done or error status.

Parameters:
MAX_LEN, 16, maximum payload bytes per frame (buffer depth); legal range 1..255
TIMEOUT_CYC, 65535, sys_clk cycles allowed between bytes inside a frame; legal range 1..2^20-1

Ports:
sys_clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
cs_n  in  1  chip select, already synchronized to sys_clk, active-low
rx_valid  in  1  one-cycle strobe: rx_byte holds a new byte
rx_byte  in  8  received byte, MSB-first assembled
wr_en  out  1  register write request, held until accepted
wr_addr  out  7  write address
wr_data  out  8  write data
wr_ready  in  1  register bus accepts the write when wr_en & wr_ready
rd_req  out  1  one-cycle read request pulse
rd_addr  out  7  read start address, valid with rd_req
rd_len  out  8  read byte count, valid with rd_req
frame_done  out  1  one-cycle pulse, frame completed OK
frame_err  out  1  one-cycle pulse, frame aborted
err_code  out  3  0 none, 1 bad length, 2 checksum, 3 early CS release, 4 timeout; holds until next frame start
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: all outputs 0; state IDLE; buffer pointers, checksum and timeout counter cleared. Reset mid-frame discards everything, and no wr_en is issued afterwards.
- Frame format:
  - byte0 CMD: bit7 = 1 write / 0 read; bits[6:0] = start address.
  - byte1 LEN: payload length.
  - Write frames: LEN data bytes follow.
  - Last byte CSUM: XOR of all preceding frame bytes.
- IDLE:
  - cs_n == 0 moves to CMD next cycle; err_code clears to 0 on this transition.
  - rx_valid while in IDLE is ignored.
- CMD: on rx_valid, latch dir/addr, set csum = byte, go to LEN.
- LEN: on rx_valid:
  - byte == 0 or byte > MAX_LEN: frame_err pulse with code 1, go to DRAIN. This applies to read frames too.
  - Otherwise latch length, fold the byte into csum, and go to DATA (write) or CSUM (read).
- DATA: each rx_valid stores the byte at buffer[idx], folds it into csum and increments idx. When idx reaches length, go to CSUM.
- CSUM: on rx_valid compare byte with csum.
  - Mismatch: frame_err pulse with code 2, go to DRAIN.
  - Match, write frame: go to COMMIT.
  - Match, read frame: rd_req pulses the next cycle with rd_addr/rd_len, frame_done pulses in the same cycle, then go to DRAIN.
- COMMIT:
  - wr_en rises the cycle after the CSUM byte, with wr_addr = start + k (mod 128) and wr_data = buffer[k].
  - wr_en, wr_addr and wr_data stay stable until a cycle with wr_ready == 1. The next entry is presented the following cycle, with no gap.
  - frame_done pulses the cycle after the last handshake, then go to DRAIN.
  - COMMIT ignores cs_n and rx_valid.
- DRAIN: ignore rx_valid; go to IDLE in the cycle after cs_n is sampled high.
- Early CS release: cs_n == 1 while in CMD/LEN/DATA/CSUM gives a frame_err pulse with code 3 and returns to IDLE.
  - If rx_valid arrives in the same cycle, the byte is processed first.
  - If that byte is a matching CSUM, the frame succeeds and no error is raised.
- Timeout:
  - The counter clears on entering CMD and on every rx_valid, and increments in CMD/LEN/DATA/CSUM.
  - Reaching TIMEOUT_CYC gives a frame_err pulse with code 4 and goes to DRAIN.
  - rx_valid in the same cycle wins over the timeout.
- frame_done and frame_err never assert in the same cycle. Exactly one of them pulses per frame that leaves CMD; a CS release while in IDLE produces neither.

Test Plan:
- Write frame 90 02 AA 55 6D, wr_ready = 1: wr_en for two consecutive cycles, (0x10, AA) then (0x11, 55); frame_done one cycle later; err_code 0.
- Same frame with CSUM 6C: frame_err with err_code 2; wr_en never asserts.
- Read frame 05 04 01: one rd_req pulse with rd_addr 0x05, rd_len 4, frame_done in the same cycle; no wr_en.
- Frame FF 02 11 22 CE with wr_ready low for 3 cycles on the first entry: (0x7F, 11) held 4 cycles, then (0x00, 22) for 1 cycle (address wrap), then frame_done.
- Length byte 00, or 17 with MAX_LEN = 16: frame_err with code 1; later bytes ignored until cs_n goes high, then IDLE.
- cs_n released after 90 02 AA: frame_err code 3, no writes.
- TIMEOUT_CYC = 100, stall 100 cycles after LEN: frame_err code 4.
- Reset asserted during COMMIT: outputs 0 immediately and no further wr_en.

Source files
------------

// File: rtl/spi_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spi_rx_frame_ctrl
// Purpose  : Parses CMD/LEN/DATA/CSUM frames from the SPI byte receiver and
//            commits checksummed write payloads or issues a read request.
// Revision : 1.0
// ============================================================================
module spi_rx_frame_ctrl #(
   parameter int MAX_LEN     = 16,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic       sys_clk,
   input  logic       rst_n,
   input  logic       cs_n_i,
   input  logic       rx_valid_i,
   input  logic [7:0] rx_byte_i,
   output logic       wr_en_o,
   output logic [6:0] wr_addr_o,
   output logic [7:0] wr_data_o,
   input  logic       wr_ready_i,
   output logic       rd_req_o,
   output logic [6:0] rd_addr_o,
   output logic [7:0] rd_len_o,
   output logic       frame_done_o,
   output logic       frame_err_o,
   output logic [2:0] err_code_o,
   output logic       busy_o
);

   localparam int          c_IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int          c_DEPTH   = 1 << c_IDX_W;
   localparam logic [7:0]  c_MAX_LEN = MAX_LEN[7:0];
   localparam logic [19:0] c_TMO     = TIMEOUT_CYC[19:0];

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CMD    = 3'd1,
      ST_LEN    = 3'd2,
      ST_DATA   = 3'd3,
      ST_CSUM   = 3'd4,
      ST_COMMIT = 3'd5,
      ST_DRAIN  = 3'd6
   } state_t;

   state_t      state_q;
   logic        dir_q;
   logic [6:0]  addr_q;
   logic [7:0]  len_q;
   logic [7:0]  idx_q;
   logic [7:0]  csum_q;
   logic [19:0] tmo_q;
   logic [7:0]  mem_q [c_DEPTH];

   logic        wr_en_q;
   logic [6:0]  wr_addr_q;
   logic [7:0]  wr_data_q;
   logic        rd_req_q;
   logic [6:0]  rd_addr_q;
   logic [7:0]  rd_len_q;
   logic        frame_done_q;
   logic        frame_err_q;
   logic [2:0]  err_code_q;

   logic        w_len_bad;
   logic        w_csum_ok;
   logic        w_ends;
   logic        w_tmo_hit;
   logic [7:0]  w_idx_nxt;

   assign w_len_bad = (rx_byte_i == 8'h00) || (rx_byte_i > c_MAX_LEN);
   assign w_csum_ok = (rx_byte_i == csum_q);
   assign w_tmo_hit = ((tmo_q + 20'd1) == c_TMO);
   assign w_idx_nxt = idx_q + 8'd1;
   // A byte that terminates the frame takes precedence over a CS release in the same cycle
   assign w_ends    = rx_valid_i && (((state_q == ST_LEN) && w_len_bad) || (state_q == ST_CSUM));

   always_ff @(posedge sys_clk) begin
      if ((state_q == ST_DATA) && rx_valid_i) begin
         mem_q[idx_q[c_IDX_W-1:0]] <= rx_byte_i;
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         dir_q        <= 1'b0;
         addr_q       <= '0;
         len_q        <= '0;
         idx_q        <= '0;
         csum_q       <= '0;
         tmo_q        <= '0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         rd_req_q     <= 1'b0;
         rd_addr_q    <= '0;
         rd_len_q     <= '0;
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
         err_code_q   <= '0;
      end else begin
         rd_req_q     <= 1'b0;
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (!cs_n_i) begin
                  state_q    <= ST_CMD;
                  err_code_q <= 3'd0;
                  tmo_q      <= '0;
               end
            end
            ST_CMD, ST_LEN, ST_DATA, ST_CSUM: begin
               if (rx_valid_i) begin
                  tmo_q <= '0;
                  case (state_q)
                     ST_CMD: begin
                        dir_q   <= rx_byte_i[7];
                        addr_q  <= rx_byte_i[6:0];
                        csum_q  <= rx_byte_i;
                        state_q <= ST_LEN;
                     end
                     ST_LEN: begin
                        if (w_len_bad) begin
                           frame_err_q <= 1'b1;
                           err_code_q  <= 3'd1;
                           state_q     <= ST_DRAIN;
                        end else begin
                           len_q   <= rx_byte_i;
                           csum_q  <= csum_q ^ rx_byte_i;
                           idx_q   <= '0;
                           state_q <= dir_q ? ST_DATA : ST_CSUM;
                        end
                     end
                     ST_DATA: begin
                        csum_q <= csum_q ^ rx_byte_i;
                        idx_q  <= w_idx_nxt;
                        if (w_idx_nxt == len_q) begin
                           state_q <= ST_CSUM;
                        end
                     end
                     default: begin
                        if (!w_csum_ok) begin
                           frame_err_q <= 1'b1;
                           err_code_q  <= 3'd2;
                           state_q     <= ST_DRAIN;
                        end else if (dir_q) begin
                           wr_en_q   <= 1'b1;
                           wr_addr_q <= addr_q;
                           wr_data_q <= mem_q[{c_IDX_W{1'b0}}];
                           idx_q     <= '0;
                           state_q   <= ST_COMMIT;
                        end else begin
                           rd_req_q     <= 1'b1;
                           rd_addr_q    <= addr_q;
                           rd_len_q     <= len_q;
                           frame_done_q <= 1'b1;
                           state_q      <= ST_DRAIN;
                        end
                     end
                  endcase
               end else if (w_tmo_hit) begin
                  frame_err_q <= 1'b1;
                  err_code_q  <= 3'd4;
                  state_q     <= ST_DRAIN;
               end else begin
                  tmo_q <= tmo_q + 20'd1;
               end
               if (cs_n_i && !w_ends) begin
                  frame_err_q <= 1'b1;
                  err_code_q  <= 3'd3;
                  state_q     <= ST_IDLE;
               end
            end
            ST_COMMIT: begin
               if (wr_ready_i) begin
                  if (w_idx_nxt == len_q) begin
                     wr_en_q      <= 1'b0;
                     frame_done_q <= 1'b1;
                     state_q      <= ST_DRAIN;
                  end else begin
                     idx_q     <= w_idx_nxt;
                     wr_addr_q <= addr_q + w_idx_nxt[6:0];
                     wr_data_q <= mem_q[w_idx_nxt[c_IDX_W-1:0]];
                  end
               end
            end
            ST_DRAIN: begin
               if (cs_n_i) begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign wr_en_o      = wr_en_q;
   assign wr_addr_o    = wr_addr_q;
   assign wr_data_o    = wr_data_q;
   assign rd_req_o     = rd_req_q;
   assign rd_addr_o    = rd_addr_q;
   assign rd_len_o     = rd_len_q;
   assign frame_done_o = frame_done_q;
   assign frame_err_o  = frame_err_q;
   assign err_code_o   = err_code_q;
   assign busy_o       = (state_q != ST_IDLE);

endmodule
`default_nettype wire
